seq_feed_ctrl: RTL and testbench

Controller that sequences a serial pattern detector (Moore-style sequence detector with a 1-bit `din` and a 1-bit `dout`).
- On `start`, latches a parallel pattern word, pulses a detector clear, then shifts the word into the detector one bit per cycle.
- Counts detector hits that fall inside the stream window, then reports `done`.
- Replaces hand-driven bench stimulus with a reusable on-chip stimulus and measurement sequencer.

---
 rtl/seq_feed_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seq_feed_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_feed_ctrl.sv
// -----------------------------------------------------------------------------
// seq_feed_ctrl
//
// Runs one pattern through a serial sequence detector and measures it. When
// `start` is accepted in IDLE, the controller:
//   1. latches `pattern`,
//   2. pulses `det_clr` for one cycle (CLEAR),
//   3. streams the word one bit per cycle on `det_din` (SHIFT),
//   4. waits DET_LAT cycles so the last bit's result can arrive (DRAIN),
//   5. pulses `done` for one cycle (DONE).
// Detector hits (`det_dout`=1) are counted only while a DET_LAT-delayed copy of
// `det_valid` is high. The count saturates at its maximum value.
//
// Build option:
//   SEQ_FEED_MSB_FIRST_EN  when defined, pattern[WIDTH-1] is sent first.
//                          Otherwise pattern[0] is sent first.
//
// Parameters:
//   WIDTH    pattern length in bits (>= 2)
//   CNT_W    width of bit_idx / match_count (2**CNT_W > WIDTH)
//   DET_LAT  detector latency from det_din to det_dout, in cycles (1..4)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   run request, honoured only in IDLE
//   pattern      in   word to stream, sampled on the accepted start edge
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse at the end of a run
//   det_clr      out  one-cycle detector resync pulse
//   det_din      out  serial bit to the detector
//   det_valid    out  det_din carries a pattern bit
//   det_dout     in   detector output
//   bit_idx      out  time position of the bit currently on det_din
//   match_count  out  hits counted in the current or last run
// -----------------------------------------------------------------------------
module seq_feed_ctrl #(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 5,
  parameter int DET_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             det_clr,
  output logic             det_din,
  output logic             det_valid,
  input  logic             det_dout,
  output logic [CNT_W-1:0] bit_idx,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] IDX_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [2:0]       DRAIN_LAST = 3'(DET_LAT - 1);

  logic [2:0]         r_state;
  logic [WIDTH-1:0]   r_sreg;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_drain;
  logic [DET_LAT-1:0] r_vld_pipe;
  logic               r_busy;
  logic               r_done;
  logic               r_clr;
  logic               r_din;
  logic               r_valid;

  logic [2:0]         w_state_nxt;
  logic [WIDTH-1:0]   w_sreg_nxt;
  logic [CNT_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]         w_drain_nxt;
  logic [DET_LAT-1:0] w_pipe_nxt;
  logic               w_din_nxt;
  logic               w_sreg_out;
  logic [WIDTH-1:0]   w_sreg_shift;
  logic               w_start_ok;
  logic               w_win;

  // Bit order: the outgoing bit is taken from one end while the register
  // moves the next bit into that position.
`ifdef SEQ_FEED_MSB_FIRST_EN
  assign w_sreg_out   = r_sreg[WIDTH-1];
  assign w_sreg_shift = r_sreg << 1;
`else
  assign w_sreg_out   = r_sreg[0];
  assign w_sreg_shift = r_sreg >> 1;
`endif

  assign w_start_ok = (r_state == S_IDLE) && start;
  // Valid delayed by the detector latency marks cycles whose det_dout belongs
  // to a streamed bit.
  assign w_win      = r_vld_pipe[DET_LAT-1];

  // Next-state, shift register, bit index and drain counter.
  // The bit for the coming SHIFT cycle is launched together with the shift, so
  // det_din is a plain register and still equals the register end bit.
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_idx_nxt   = r_idx;
    w_drain_nxt = r_drain;
    w_din_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CLEAR;
          w_sreg_nxt  = pattern;
          w_idx_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_SHIFT;
        w_din_nxt   = w_sreg_out;
        w_sreg_nxt  = w_sreg_shift;
        w_idx_nxt   = {CNT_W{1'b0}};
      end
      S_SHIFT: begin
        if (r_idx == IDX_LAST) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = 3'd0;
        end else begin
          w_state_nxt = S_SHIFT;
          w_din_nxt   = w_sreg_out;
          w_sreg_nxt  = w_sreg_shift;
          w_idx_nxt   = r_idx + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_drain_nxt = r_drain + 3'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Hit counter: cleared on an accepted start, saturating increment in window.
  always_comb begin
    if (w_start_ok) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (w_win && det_dout && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Valid delay line; stage 0 takes the det_valid that is currently driven.
  always_comb begin
    w_pipe_nxt    = r_vld_pipe << 1;
    w_pipe_nxt[0] = r_valid;
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sreg     <= {WIDTH{1'b0}};
      r_idx      <= {CNT_W{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_drain    <= 3'd0;
      r_vld_pipe <= {DET_LAT{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clr      <= 1'b0;
      r_din      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sreg     <= w_sreg_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_drain    <= w_drain_nxt;
      r_vld_pipe <= w_pipe_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_clr      <= (w_state_nxt == S_CLEAR);
      r_din      <= w_din_nxt;
      r_valid    <= (w_state_nxt == S_SHIFT);
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign det_clr     = r_clr;
  assign det_din     = r_din;
  assign det_valid   = r_valid;
  assign bit_idx     = r_idx;
  assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_feed_ctrl.sv
// Bench for seq_feed_ctrl (default LSB-first build, WIDTH=16, DET_LAT=1).
// Cycle numbering: start is sampled at edge 0; cycle c is the interval after
// edge c-1. Outputs are sampled 1 time unit after each rising edge.
module tb_seq_feed_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic        busy, done, det_clr, det_din, det_valid, det_dout;
  logic [4:0]  bit_idx, match_count;

  // Second instance with a narrow counter, detector output tied high.
  logic        start2;
  logic        busy2, done2, det_clr2, det_din2, det_valid2;
  logic [3:0]  bit_idx2, match_count2;

  int          mode;     // 0 echo, 1 always 1, 2 high only in IDLE/DONE, 3 always 0
  logic        r_echo;
  int          checks;
  int          errors;

  typedef struct {
    logic [15:0] pat;
    int          mode;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t vecs [8];

  seq_feed_ctrl #(.WIDTH(16), .CNT_W(5), .DET_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .det_clr(det_clr), .det_din(det_din),
    .det_valid(det_valid), .det_dout(det_dout), .bit_idx(bit_idx),
    .match_count(match_count)
  );

  seq_feed_ctrl #(.WIDTH(16), .CNT_W(4), .DET_LAT(1)) u_dut4 (
    .clk(clk), .reset(reset), .start(start2), .pattern(pattern),
    .busy(busy2), .done(done2), .det_clr(det_clr2), .det_din(det_din2),
    .det_valid(det_valid2), .det_dout(1'b1), .bit_idx(bit_idx2),
    .match_count(match_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle echo detector model.
  initial r_echo = 1'b0;
  always @(posedge clk) r_echo <= det_din;

  always_comb begin
    case (mode)
      0:       det_dout = r_echo;
      1:       det_dout = 1'b1;
      2:       det_dout = (!busy) || done;
      default: det_dout = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected per-cycle outputs of a 16-bit run, computed from the cycle number.
  task automatic chk_cycle(input int c, input logic [15:0] pat, input string tag);
    logic       e_valid, e_din;
    logic [4:0] e_idx;
    e_valid = (c >= 2) && (c <= 17);
    e_din   = 1'b0;
    if (e_valid) e_din = pat[c-2];
    if (c <= 2)       e_idx = 5'd0;
    else if (c <= 17) e_idx = 5'(c - 2);
    else              e_idx = 5'd15;
    chk($sformatf("%s c%0d busy", tag, c),  busy,      (c <= 19) ? 1 : 0);
    chk($sformatf("%s c%0d done", tag, c),  done,      (c == 19) ? 1 : 0);
    chk($sformatf("%s c%0d clr", tag, c),   det_clr,   (c == 1) ? 1 : 0);
    chk($sformatf("%s c%0d valid", tag, c), det_valid, e_valid);
    chk($sformatf("%s c%0d din", tag, c),   det_din,   e_din);
    chk($sformatf("%s c%0d idx", tag, c),   bit_idx,   e_idx);
  endtask

  // Full run from IDLE; pattern is disturbed right after acceptance.
  task automatic run_vec(input vec_t v, input string tag);
    mode    = v.mode;
    pattern = v.pat;
    start   = 1'b1;
    step();
    start   = 1'b0;
    pattern = ~v.pat;
    for (int c = 1; c <= 20; c++) begin
      chk_cycle(c, v.pat, tag);
      if (c == 1)  chk($sformatf("%s cleared", tag), match_count, 5'd0);
      if (c >= 19) chk($sformatf("%s count c%0d", tag, c), match_count, v.exp_cnt);
      step();
    end
  endtask

  initial begin
    int done_seen;
    checks  = 0;
    errors  = 0;
    mode    = 0;
    start   = 1'b0;
    start2  = 1'b0;
    pattern = 16'h0000;
    reset   = 1'b0;

    vecs[0] = '{pat: 16'hDB6D, mode: 0, exp_cnt: 5'd11};
    vecs[1] = '{pat: 16'h0000, mode: 0, exp_cnt: 5'd0};
    vecs[2] = '{pat: 16'hFFFF, mode: 0, exp_cnt: 5'd16};
    vecs[3] = '{pat: 16'hAAAA, mode: 0, exp_cnt: 5'd8};
    vecs[4] = '{pat: 16'h8001, mode: 0, exp_cnt: 5'd2};
    vecs[5] = '{pat: 16'h0000, mode: 1, exp_cnt: 5'd16};
    vecs[6] = '{pat: 16'hFFFF, mode: 2, exp_cnt: 5'd0};
    vecs[7] = '{pat: 16'hFFFF, mode: 3, exp_cnt: 5'd0};

    // Reset state.
    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst clr", det_clr, 0);
    chk("rst din", det_din, 0);
    chk("rst valid", det_valid, 0);
    chk("rst idx", bit_idx, 0);
    chk("rst cnt", match_count, 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("idle busy", busy, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Saturation on the 4-bit counter instance.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done2) done_seen++;
      if (c == 19) chk("sat done", done2, 1);
      step();
    end
    chk("sat count", match_count2, 4'd15);
    chk("sat done pulses", done_seen, 1);

    // start re-pulsed in SHIFT and DONE is ignored; start in next IDLE restarts.
    mode    = 0;
    pattern = 16'hFFFF;
    start   = 1'b1;
    step();
    start   = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= 19; c++) begin
      chk_cycle(c, 16'hFFFF, "rep");
      if (done) done_seen++;
      start = (c == 5) || (c == 19);
      if (c == 19) pattern = 16'h0003;
      step();
    end
    start = 1'b0;
    chk("rep c20 busy", busy, 0);
    chk("rep c20 done", done, 0);
    chk("rep c20 count", match_count, 5'd16);
    chk("rep done pulses", done_seen, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart clr", det_clr, 1);
    chk("restart cleared", match_count, 5'd0);
    for (int c = 2; c <= 20; c++) begin
      step();
      if (c == 19) chk("restart done", done, 1);
    end
    chk("restart count", match_count, 5'd2);

    // Reset in the middle of SHIFT.
    pattern = 16'hDB6D;
    start   = 1'b1;
    step();
    start   = 1'b0;
    for (int c = 1; c < 9; c++) step();
    chk("mid idx7", bit_idx, 5'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("mid busy", busy, 0);
    chk("mid valid", det_valid, 0);
    chk("mid cnt", match_count, 0);
    chk("mid idx", bit_idx, 0);
    chk("mid din", det_din, 0);
    step();
    chk("mid done", done, 0);
    step();
    reset = 1'b1;
    step();
    run_vec(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
